// File: rtl/dvi_iic_sched_if.sv
// Transaction bus between the DVI register-write scheduler and the I2C write engine.
// The scheduler drives requests (master); the engine accepts and reports completion (slave).
interface dvi_iic_sched_if;
  logic       Txn_valid;
  logic       Txn_ready;
  logic [6:0] Txn_slave;
  logic [7:0] Txn_reg;
  logic [7:0] Txn_data;
  logic       Txn_done;
  logic       Txn_nack;

  modport master (
    output Txn_valid, Txn_slave, Txn_reg, Txn_data,
    input  Txn_ready, Txn_done, Txn_nack
  );

  modport slave (
    input  Txn_valid, Txn_slave, Txn_reg, Txn_data,
    output Txn_ready, Txn_done, Txn_nack
  );
endinterface

// File: rtl/dvi_iic_sched.sv
// Serialises DVI transmitter register writes onto one I2C write engine: a fixed
// power-up init table first, then host writes, with NACK retry after an idle gap.
module dvi_iic_sched #(
  parameter logic [6:0]  SLAVE_ADDR       = 7'h76,
  parameter int unsigned MAX_RETRY        = 3,
  parameter int unsigned RETRY_GAP_CYCLES = 6000,
  parameter int unsigned CNT_W            = 16
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  i_Hi_res,
  input  logic                  i_Host_req,
  input  logic [7:0]            i_Host_reg,
  input  logic [7:0]            i_Host_data,
  output logic                  o_Host_done,
  output logic                  o_Host_err,
  output logic                  o_Init_done,
  output logic                  o_Init_err,
  output logic                  o_Busy,
  dvi_iic_sched_if.master       txn
);

  localparam int unsigned IDX_W   = 3;
  localparam int unsigned RTY_W   = $clog2(MAX_RETRY + 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(4);

  typedef enum logic [2:0] {
    S_SEL,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_IDLE
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [RTY_W-1:0] r_retry;
  logic [CNT_W-1:0] r_cnt;
  logic             r_src_host;
  logic             r_hires;
  logic             r_hires_vld;
  logic             r_valid;
  logic [7:0]       r_reg;
  logic [7:0]       r_data;
  logic             r_host_done;
  logic             r_host_err;
  logic             r_init_done;
  logic             r_init_err;
  logic             r_busy;
  logic             w_hires;

  // Until the first post-reset edge has latched Hi_res, use the live pin.
  assign w_hires = r_hires_vld ? r_hires : i_Hi_res;

  // Init table entry {reg, data}; entries 2..4 depend on the pixel-clock range.
  function automatic logic [15:0] init_entry(input logic [IDX_W-1:0] idx, input logic hires);
    logic [15:0] v;
    case (idx)
      IDX_W'(0): v = 16'h49C0;
      IDX_W'(1): v = 16'h2109;
      IDX_W'(2): v = hires ? 16'h3306 : 16'h3308;
      IDX_W'(3): v = hires ? 16'h3426 : 16'h3416;
      IDX_W'(4): v = hires ? 16'h36A0 : 16'h3660;
      default:   v = 16'h0000;
    endcase
    return v;
  endfunction

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state     <= S_SEL;
      r_idx       <= '0;
      r_retry     <= '0;
      r_cnt       <= '0;
      r_src_host  <= 1'b0;
      r_hires     <= 1'b0;
      r_hires_vld <= 1'b0;
      r_valid     <= 1'b0;
      r_reg       <= 8'h00;
      r_data      <= 8'h00;
      r_host_done <= 1'b0;
      r_host_err  <= 1'b0;
      r_init_done <= 1'b0;
      r_init_err  <= 1'b0;
      r_busy      <= 1'b1;
    end else begin
      r_host_done <= 1'b0;
      r_busy      <= 1'b1;
      if (!r_hires_vld) begin
        r_hires     <= i_Hi_res;
        r_hires_vld <= 1'b1;
      end

      case (r_state)
        S_SEL: begin
          if (!r_init_done) begin
            {r_reg, r_data} <= init_entry(r_idx, w_hires);
            r_src_host      <= 1'b0;
            r_retry         <= '0;
            r_state         <= S_ISSUE;
          end else if (i_Host_req && !r_host_done) begin
            // r_host_done still high means this request was just completed.
            r_reg      <= i_Host_reg;
            r_data     <= i_Host_data;
            r_src_host <= 1'b1;
            r_retry    <= '0;
            r_state    <= S_ISSUE;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        S_ISSUE: begin
          if (r_valid && txn.Txn_ready) begin
            r_valid <= 1'b0;
            r_state <= S_WAIT;
          end else begin
            r_valid <= 1'b1;
          end
        end

        S_WAIT: begin
          if (txn.Txn_done) begin
            if (txn.Txn_nack && (r_retry < RTY_W'(MAX_RETRY))) begin
              r_retry <= r_retry + RTY_W'(1);
              r_cnt   <= '0;
              r_state <= S_GAP;
            end else begin
              r_state <= S_SEL;
              if (r_src_host) begin
                r_host_done <= 1'b1;
                r_host_err  <= txn.Txn_nack;
              end else begin
                r_idx <= r_idx + IDX_W'(1);
                if (txn.Txn_nack) r_init_err <= 1'b1;
                if (r_idx == LAST_IDX) r_init_done <= 1'b1;
              end
            end
          end
        end

        // Raise Txn_valid as the gap ends so exactly RETRY_GAP_CYCLES idle cycles separate attempts.
        S_GAP: begin
          if (r_cnt == CNT_W'(RETRY_GAP_CYCLES - 1)) begin
            r_valid <= 1'b1;
            r_state <= S_ISSUE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_IDLE: begin
          if (i_Host_req) r_state <= S_SEL;
          else            r_busy  <= 1'b0;
        end

        default: r_state <= S_SEL;
      endcase
    end
  end

  assign txn.Txn_valid = r_valid;
  assign txn.Txn_slave = SLAVE_ADDR;
  assign txn.Txn_reg   = r_reg;
  assign txn.Txn_data  = r_data;
  assign o_Host_done   = r_host_done;
  assign o_Host_err    = r_host_err;
  assign o_Init_done   = r_init_done;
  assign o_Init_err    = r_init_err;
  assign o_Busy        = r_busy;

endmodule

// File: tb/tb_dvi_iic_sched.sv
// Directed bench for dvi_iic_sched: init table variants, NACK retry and gap,
// init/host arbitration, host retry exhaustion, and reset in the middle of a write.
module tb_dvi_iic_sched;

  logic       Clk;
  logic       Reset_n;
  logic       i_Hi_res;
  logic       i_Host_req;
  logic [7:0] i_Host_reg;
  logic [7:0] i_Host_data;
  logic       o_Host_done;
  logic       o_Host_err;
  logic       o_Init_done;
  logic       o_Init_err;
  logic       o_Busy;

  int n_checks;
  int n_errors;

  dvi_iic_sched_if bus ();

  dvi_iic_sched #(
    .SLAVE_ADDR       (7'h76),
    .MAX_RETRY        (3),
    .RETRY_GAP_CYCLES (6000),
    .CNT_W            (16)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .i_Hi_res    (i_Hi_res),
    .i_Host_req  (i_Host_req),
    .i_Host_reg  (i_Host_reg),
    .i_Host_data (i_Host_data),
    .o_Host_done (o_Host_done),
    .o_Host_err  (o_Host_err),
    .o_Init_done (o_Init_done),
    .o_Init_err  (o_Init_err),
    .o_Busy      (o_Busy),
    .txn         (bus.master)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Engine model: wait for a request, check its fields, optionally stall, accept,
  // then report completion 20 cycles after accept. Returns one cycle after Txn_done.
  task automatic serve(input string tag, input logic [7:0] er, input logic [7:0] ed,
                       input logic nack, input int stall);
    int   n;
    logic stable;
    n = 0;
    while (bus.Txn_valid !== 1'b1 && n < 20000) begin
      @(negedge Clk);
      n++;
    end
    check({tag, "_valid"}, 32'(bus.Txn_valid), 32'd1);
    check({tag, "_slave"}, 32'(bus.Txn_slave), 32'h76);
    check({tag, "_reg"},   32'(bus.Txn_reg),   32'(er));
    check({tag, "_data"},  32'(bus.Txn_data),  32'(ed));
    stable = 1'b1;
    for (int i = 0; i < stall; i++) begin
      bus.Txn_ready = 1'b0;
      @(negedge Clk);
      if (bus.Txn_valid !== 1'b1 || bus.Txn_reg !== er || bus.Txn_data !== ed) stable = 1'b0;
    end
    if (stall > 0) check({tag, "_stall"}, 32'(stable), 32'd1);
    bus.Txn_ready = 1'b1;
    @(negedge Clk);
    bus.Txn_ready = 1'b0;
    check({tag, "_drop"}, 32'(bus.Txn_valid), 32'd0);
    repeat (19) @(negedge Clk);
    bus.Txn_done = 1'b1;
    bus.Txn_nack = nack;
    @(negedge Clk);
    bus.Txn_done = 1'b0;
    bus.Txn_nack = 1'b0;
  endtask

  initial begin
    int n;
    n_checks      = 0;
    n_errors      = 0;
    Reset_n       = 1'b0;
    i_Hi_res      = 1'b0;
    i_Host_req    = 1'b0;
    i_Host_reg    = 8'h00;
    i_Host_data   = 8'h00;
    bus.Txn_ready = 1'b0;
    bus.Txn_done  = 1'b0;
    bus.Txn_nack  = 1'b0;

    repeat (3) @(negedge Clk);
    check("rst_valid",     32'(bus.Txn_valid), 32'd0);
    check("rst_reg",       32'(bus.Txn_reg),   32'd0);
    check("rst_data",      32'(bus.Txn_data),  32'd0);
    check("rst_host_done", 32'(o_Host_done),   32'd0);
    check("rst_host_err",  32'(o_Host_err),    32'd0);
    check("rst_init_done", 32'(o_Init_done),   32'd0);
    check("rst_init_err",  32'(o_Init_err),    32'd0);
    check("rst_busy",      32'(o_Busy),        32'd1);
    Reset_n = 1'b1;

    // Run 1: low-res table, entry 0 always NACKs, Hi_res toggled after latch.
    for (int a = 0; a < 4; a++) serve("r1_e0", 8'h49, 8'hC0, 1'b1, 0);
    check("r1_init_err",  32'(o_Init_err),  32'd1);
    check("r1_init_done", 32'(o_Init_done), 32'd0);
    i_Hi_res = 1'b1;
    serve("r1_e1", 8'h21, 8'h09, 1'b0, 0);
    serve("r1_e2", 8'h33, 8'h08, 1'b0, 0);

    // Entry 3: accept, then reset while waiting for completion.
    n = 0;
    while (bus.Txn_valid !== 1'b1 && n < 20000) begin
      @(negedge Clk);
      n++;
    end
    check("r1_e3_reg",  32'(bus.Txn_reg),  32'h34);
    check("r1_e3_data", 32'(bus.Txn_data), 32'h16);
    bus.Txn_ready = 1'b1;
    @(negedge Clk);
    bus.Txn_ready = 1'b0;
    check("r1_e3_drop", 32'(bus.Txn_valid), 32'd0);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    check("mid_rst_valid",     32'(bus.Txn_valid), 32'd0);
    check("mid_rst_reg",       32'(bus.Txn_reg),   32'd0);
    check("mid_rst_init_done", 32'(o_Init_done),   32'd0);
    check("mid_rst_init_err",  32'(o_Init_err),    32'd0);
    check("mid_rst_busy",      32'(o_Busy),        32'd1);
    @(negedge Clk);
    bus.Txn_done = 1'b1;
    @(negedge Clk);
    bus.Txn_done = 1'b0;

    // Run 2: restarted init with Hi_res=1 latched; host request arrives during entry 1.
    serve("r2_e0", 8'h49, 8'hC0, 1'b0, 0);
    check("r2_init_err_e0", 32'(o_Init_err), 32'd0);
    i_Host_req  = 1'b1;
    i_Host_reg  = 8'h1C;
    i_Host_data = 8'h04;
    serve("r2_e1",  8'h21, 8'h09, 1'b0, 0);
    serve("r2_e2a", 8'h33, 8'h06, 1'b1, 0);
    n = 0;
    while (bus.Txn_valid !== 1'b1 && n < 20000) begin
      n++;
      @(negedge Clk);
    end
    check("r2_gap_cycles", 32'(n), 32'd6000);
    serve("r2_e2b", 8'h33, 8'h06, 1'b0, 0);
    serve("r2_e3",  8'h34, 8'h26, 1'b0, 0);
    serve("r2_e4",  8'h36, 8'hA0, 1'b0, 0);
    check("r2_init_done", 32'(o_Init_done), 32'd1);
    check("r2_init_err",  32'(o_Init_err),  32'd0);
    check("r2_no_host_done_yet", 32'(o_Host_done), 32'd0);
    serve("r2_host", 8'h1C, 8'h04, 1'b0, 50);
    check("r2_host_done", 32'(o_Host_done), 32'd1);
    check("r2_host_err",  32'(o_Host_err),  32'd0);
    i_Host_req = 1'b0;
    repeat (3) @(negedge Clk);
    check("r2_host_done_pulse", 32'(o_Host_done), 32'd0);
    check("r2_busy_idle",       32'(o_Busy),      32'd0);
    check("r2_valid_idle",      32'(bus.Txn_valid), 32'd0);

    // Run 3: host request from IDLE reaches Txn_valid on the third edge, then exhausts retries.
    i_Host_req  = 1'b1;
    i_Host_reg  = 8'hAA;
    i_Host_data = 8'h55;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (bus.Txn_valid !== 1'b1 && n < 10);
    check("r3_latency", 32'(n), 32'd3);
    for (int a = 0; a < 4; a++) serve("r3_host", 8'hAA, 8'h55, 1'b1, 0);
    check("r3_host_done", 32'(o_Host_done), 32'd1);
    check("r3_host_err",  32'(o_Host_err),  32'd1);
    check("r3_init_err",  32'(o_Init_err),  32'd0);
    i_Host_req = 1'b0;
    repeat (3) @(negedge Clk);
    check("r3_busy_idle", 32'(o_Busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dvi_iic_sched.md
Name: dvi_iic_sched

Overview:
Sequences all register writes to the DVI transmitter over a shared I2C write engine. At power-up it walks a fixed 5-entry init table (contents selected by pixel-clock range), then arbitrates runtime host register writes onto the same engine. It retries NACKed transactions, reports init completion and errors, and sits between the video-init logic and the single I2C bit-level engine on the board.

Parameters:
SLAVE_ADDR, 7'h76, 7-bit I2C address driven on Txn_slave for every transaction
MAX_RETRY, 3, re-issues allowed after a NACK (total attempts = MAX_RETRY+1)
RETRY_GAP_CYCLES, 6000, idle Clk cycles between a NACK and the re-issue
CNT_W, 16, width of the gap counter; must hold RETRY_GAP_CYCLES

Ports:
Clk  in  1  system clock
Reset_n  in  1  synchronous active-low reset
Hi_res  in  1  1 = pixel clock >65 MHz table variant
Host_req  in  1  host write request; held high, fields stable, until Host_done
Host_reg  in  8  host register address
Host_data  in  8  host write data
Host_done  out  1  one-cycle pulse, host transaction finished
Host_err  out  1  valid with Host_done; 1 = retries exhausted
Txn_valid  out  1  transaction request to engine
Txn_ready  in  1  engine accepts when Txn_valid&Txn_ready
Txn_slave  out  7  slave address
Txn_reg  out  8  register address
Txn_data  out  8  data byte
Txn_done  in  1  one-cycle pulse, engine finished (incl. STOP)
Txn_nack  in  1  valid with Txn_done; 1 = any byte NACKed
Init_done  out  1  sticky, init table finished
Init_err  out  1  sticky, at least one init entry exhausted retries
Busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset_n is synchronous, active-low; clock is Clk. Reset values: Txn_valid=0, Txn_reg=0, Txn_data=0, Host_done=0, Host_err=0, Init_done=0, Init_err=0, Busy=1, entry index=0, retry count=0, state=SEL.
- Hi_res is latched on the first Clk edge with Reset_n high and held until the next reset. Mid-init changes are ignored.
- Init table, in order (reg/data, a = Hi_res 1, b = Hi_res 0):
  - 0: 49/C0
  - 1: 21/09
  - 2: 33/06a, 08b
  - 3: 34/26a, 16b
  - 4: 36/A0a, 60b
- States:
  - SEL: if Init_done=0, load the init entry at index. Else if Host_req=1 and no Host_done was pulsed in the previous cycle, load Host_reg/Host_data and set src=host. Else go to IDLE. Loading clears the retry count and moves to ISSUE.
  - ISSUE: Txn_valid=1, fields stable. On Txn_valid&Txn_ready, Txn_valid drops next cycle and the block moves to WAIT.
  - WAIT: Txn_done ignored in every other state.
    - Txn_done & !Txn_nack: success.
    - Txn_done & Txn_nack & retry<MAX_RETRY: retry+1, go to GAP.
    - Txn_done & Txn_nack & retry==MAX_RETRY: failure.
  - GAP: count RETRY_GAP_CYCLES cycles, then ISSUE with identical fields.
  - IDLE: Busy=0. Host_req=1 moves to SEL next cycle.
- Completion (success or failure):
  - Init source: index+1; failure also sets Init_err. After index 4, Init_done=1 in the same cycle as leaving WAIT. Then SEL.
  - Host source: Host_done=1 for one cycle, Host_err=failure. Then SEL.
- Arbitration: init has strict priority. Host_req during init is deferred, not dropped. After init, host is the only requester.
- Latency: ISSUE→Txn_valid in the cycle after SEL, so a host request seen in IDLE reaches Txn_valid on the third edge.
- Reset mid-transaction: everything returns to reset values and init restarts from entry 0. An engine Txn_done arriving after reset is ignored, because the state is not WAIT.
- Simultaneous Host_req with last init completion: init finishes first, then the host is served via SEL.

Test Plan:
- Hi_res=1, engine ready=1, Txn_done 20 cycles after accept, no NACK → 5 transactions in order 49/C0, 21/09, 33/06, 34/26, 36/A0, all slave 76; Init_done=1, Init_err=0.
- Hi_res=0 → entries 2–4 carry 08, 16, 60. Toggle Hi_res mid-init → data unchanged from latched value.
- NACK once on entry 2 → entry 2 re-issued exactly 6000 cycles after Txn_done with identical fields; Init_err=0.
- NACK always on entry 0 → 4 attempts, then Init_err=1 and entry 1 issued; Init_done still asserts after entry 4.
- Host_req (reg 0x1C, data 0x04) asserted during entry 1 → served only after Init_done; Host_done pulse with Host_err=0; Txn_ready held 0 for 50 cycles keeps Txn_valid high and fields stable.
- Reset_n low for 1 cycle during WAIT of entry 3, stale Txn_done 2 cycles later → Txn_done ignored, init restarts at 49/C0, Init_done/Init_err cleared.
